// File: rtl/netlist_sweep_ctrl.sv
// Exhaustive / LFSR stimulus sweeper for a 7-input combinational netlist.
// Compacts the netlist response into a 16-bit signature and a ones count.
module netlist_sweep_ctrl #(
    parameter logic [15:0] SIG_POLY = 16'h1021,
    parameter logic [15:0] SIG_SEED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [3:0]  settle_cycles,
    input  logic        abort,
    output logic [6:0]  dut_in,
    input  logic        dut_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [7:0]  ones_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  vec_q, vec_d;
    logic [6:0]  vec_nxt;
    logic        last_vec;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  settle_q, settle_d;
    logic        mode_q, mode_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] sig_shift;
    logic [7:0]  ones_q, ones_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Mode 1 walks x^7+x^6+1, which never visits 7'h00.
    always_comb begin
        if (mode_q) begin
            vec_nxt  = {vec_q[5:0], vec_q[6] ^ vec_q[5]};
            last_vec = (vec_nxt == 7'h01);
        end else begin
            vec_nxt  = vec_q + 7'd1;
            last_vec = (vec_q == 7'h7f);
        end
    end

    always_comb begin
        sig_shift = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wait_d   = wait_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        sig_d    = sig_q;
        ones_d   = ones_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d    = mode ? 7'h01 : 7'h00;
                    sig_d    = SIG_SEED;
                    ones_d   = 8'd0;
                    wait_d   = settle_cycles;
                    settle_d = settle_cycles;
                    mode_d   = mode;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sig_d  = sig_shift ^ {15'b0, dut_out};
                    ones_d = ones_q + {7'b0, dut_out};
                    if (last_vec) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_nxt;
                        wait_d  = settle_q;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= 7'h00;
            wait_q   <= 4'd0;
            settle_q <= 4'd0;
            mode_q   <= 1'b0;
            sig_q    <= SIG_SEED;
            ones_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            wait_q   <= wait_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
            sig_q    <= sig_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dut_in     = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;

endmodule

// File: doc/netlist_sweep_ctrl.md
NETLIST_SWEEP_CTRL -- requirements
Module: netlist_sweep_ctrl

Interface
REQ-001 Parameter SIG_POLY, 16'h1021, feedback polynomial of the 16-bit output signature register.
REQ-002 Parameter SIG_SEED, 16'h0000, signature value loaded at each sweep start.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start  input  1  one-cycle sweep request; honoured only in IDLE.
REQ-006 mode  input  1  0 = exhaustive binary count, 1 = 7-bit LFSR sequence; sampled with start.
REQ-007 settle_cycles  input  4  extra hold cycles per vector before capture; sampled with start.
REQ-008 abort  input  1  terminates a sweep in progress.
REQ-009 dut_in  output  7  stimulus vector driven onto the combinational netlist inputs n_0..n_6 (bit k drives n_k).
REQ-010 dut_out  input  1  netlist output under test.
REQ-011 busy  output  1  high in SETTLE and CAPTURE.
REQ-012 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-013 signature  output  16  accumulated response signature.
REQ-014 ones_count  output  8  number of captured vectors with dut_out = 1.

Function
REQ-015 FSM states: IDLE, SETTLE, CAPTURE, DONE; busy = (state is SETTLE or CAPTURE); done = (state is DONE).
REQ-016 IDLE & start: vec <= 0 (mode 0) or 7'h01 (mode 1); signature <= SIG_SEED; ones_count <= 0; wait <= settle_cycles; latch mode; -> SETTLE.
REQ-017 IDLE without start: all registers hold; dut_in holds the last driven vector.
REQ-018 dut_in = vec, registered, constant for the whole SETTLE+CAPTURE interval of each vector.
REQ-019 SETTLE: wait == 0 -> CAPTURE; otherwise wait <= wait - 1, stay in SETTLE.
REQ-020 CAPTURE: signature <= ({signature[14:0],1'b0} ^ (signature[15] ? SIG_POLY : 0)) ^ {15'b0, dut_out}; ones_count <= ones_count + dut_out.
REQ-021 CAPTURE, not last vector: advance vec; wait <= latched settle value; -> SETTLE.
REQ-022 Mode 0 advance: vec + 1; last vector is 7'h7F (128 vectors).
REQ-023 Mode 1 advance: Fibonacci LFSR, vec <= {vec[5:0], vec[6]^vec[5]}; last vector is the one whose successor is 7'h01 (127 vectors, 7'h00 never applied).
REQ-024 CAPTURE, last vector: -> DONE; DONE lasts one cycle, then -> IDLE.
REQ-025 Per-vector time = settle + 2 cycles; start-sample edge to done high = N*(settle+2) cycles, N = 128 or 127.
REQ-026 ones_count never wraps (maximum 128 fits 8 bits).
REQ-027 abort in SETTLE or CAPTURE -> IDLE next cycle; capture in that cycle suppressed; no done pulse; signature/ones_count hold partial values.
REQ-028 abort has priority over the CAPTURE transition; abort in IDLE or DONE is ignored.
REQ-029 start while busy or in DONE is ignored; start and abort together in IDLE start a sweep.
REQ-030 signature and ones_count remain stable in IDLE until the next accepted start.

Reset
REQ-031 rst_n low at a clock edge: state IDLE, vec 0, dut_in 0, wait 0, latched mode 0, signature SIG_SEED, ones_count 0, busy 0, done 0.
REQ-032 Reset mid-sweep discards the sweep without a done pulse; reset takes priority over start and abort.

Verification
REQ-033 mode 0, settle 0, dut_out tied 1 -> dut_in steps 0,1,...,127; done high exactly 256 cycles after start; ones_count 128.
REQ-034 mode 0, settle 3, dut_out tied 0, SIG_SEED 0 -> each dut_in value held 5 cycles; done after 640 cycles; signature 16'h0000; ones_count 0.
REQ-035 mode 1, settle 0, dut_out = dut_in[0] -> 127 distinct nonzero vectors, first 7'h01, second 7'h02; done after 254 cycles; ones_count 64.
REQ-036 abort asserted in the 10th cycle of a mode 0, settle 0 sweep -> IDLE next cycle, no done, ones_count equals the captures completed before abort.
REQ-037 rst_n low for 1 cycle mid-sweep, then start pulsed repeatedly while busy -> only the first post-reset start is accepted; outputs match REQ-031 values before it.
REQ-038 Reference model of the actual netlist on dut_in/dut_out, mode 0, settle 1 -> signature and ones_count equal to model-computed values.
